// File: rtl/keccak_absorb.sv
// Keccak sponge absorb controller: streams 64-bit message words into the state,
// applies pad10*1 with a run-time domain byte and sequences Keccak-f1600 calls.
module keccak_absorb (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rateInBytes,
  input  logic [15:0] inputLen_InBytes,
  input  logic [7:0]  domain_sep,
  input  logic [63:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [63:0] absorb_word,
  output logic [4:0]  state_reg_sel,
  output logic        xor_state,
  output logic        call_keccak_f1600,
  input  logic        keccak_round_complete,
  output logic        done
);

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned REM_W   = 17;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned SEL_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABSORB,
    S_PAD,
    S_PERM_REQ,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [BYTE_W-1:0]   rate_ctr_q, rate_ctr_d;
  logic [BYTE_W-1:0]   rate_q, rate_d;
  logic [BYTE_W-1:0]   dom_q, dom_d;
  logic                dom_placed_q, dom_placed_d;

  logic                din_ready_q, din_ready_d;
  logic [WORD_W-1:0]   absorb_word_q, absorb_word_d;
  logic [SEL_W-1:0]    state_reg_sel_q, state_reg_sel_d;
  logic                xor_state_q, xor_state_d;
  logic                call_q, call_d;
  logic                done_q, done_d;

  logic                rate_end;
  logic                placing;
  logic [WORD_W-1:0]   word;

  // Next-state, counter and output computation
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    rate_ctr_d      = rate_ctr_q;
    rate_d          = rate_q;
    dom_d           = dom_q;
    dom_placed_d    = dom_placed_q;
    absorb_word_d   = absorb_word_q;
    state_reg_sel_d = state_reg_sel_q;
    xor_state_d     = 1'b0;
    word            = '0;
    placing         = 1'b0;
    rate_end        = (rate_ctr_q == BYTE_W'(rate_q - 8'd8));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rate_d       = rateInBytes;
          dom_d        = domain_sep;
          rem_d        = REM_W'(inputLen_InBytes);
          rate_ctr_d   = '0;
          dom_placed_d = 1'b0;
          state_d      = (inputLen_InBytes == 16'd0) ? S_PAD : S_ABSORB;
        end
      end

      S_ABSORB: begin
        if (din_valid && din_ready_q) begin
          word    = din;
          placing = (rem_q < REM_W'(8));
          // Final partial word: zero the tail and drop the domain byte right after the data
          if (placing) begin
            for (int i = 0; i < 8; i++) begin
              if (3'(i) == rem_q[2:0]) begin
                word[8*i +: 8] = dom_q;
              end else if (3'(i) > rem_q[2:0]) begin
                word[8*i +: 8] = 8'h00;
              end
            end
          end
          if (rate_end && (dom_placed_q || placing)) begin
            word[63] = ~word[63];
          end
          xor_state_d     = 1'b1;
          absorb_word_d   = word;
          state_reg_sel_d = rate_ctr_q[7:3];
          rate_ctr_d      = BYTE_W'(rate_ctr_q + 8'd8);
          rem_d           = (rem_q >= REM_W'(8)) ? REM_W'(rem_q - REM_W'(8)) : '0;
          dom_placed_d    = dom_placed_q | placing;
          if (rate_end) begin
            state_d = S_PERM_REQ;
          end else if (rem_d == '0) begin
            state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        placing = ~dom_placed_q;
        word    = placing ? WORD_W'(dom_q) : '0;
        if (rate_end) begin
          word[63] = ~word[63];
        end
        xor_state_d     = 1'b1;
        absorb_word_d   = word;
        state_reg_sel_d = rate_ctr_q[7:3];
        rate_ctr_d      = BYTE_W'(rate_ctr_q + 8'd8);
        dom_placed_d    = 1'b1;
        if (rate_end) begin
          state_d = S_PERM_REQ;
        end
      end

      S_PERM_REQ: begin
        if (call_q && keccak_round_complete) begin
          rate_ctr_d = '0;
          if (dom_placed_q && (rem_q == '0)) begin
            state_d = S_DONE;
          end else if (rem_q != '0) begin
            state_d = S_ABSORB;
          end else begin
            state_d = S_PAD;
          end
        end
      end

      S_DONE: begin
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    din_ready_d = (state_d == S_ABSORB);
    // Request starts one cycle after entering PERM_REQ so the final XOR lands first
    call_d      = (state_q == S_PERM_REQ) && (state_d == S_PERM_REQ);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      rem_q           <= '0;
      rate_ctr_q      <= '0;
      rate_q          <= '0;
      dom_q           <= '0;
      dom_placed_q    <= 1'b0;
      din_ready_q     <= 1'b0;
      absorb_word_q   <= '0;
      state_reg_sel_q <= '0;
      xor_state_q     <= 1'b0;
      call_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      rate_ctr_q      <= rate_ctr_d;
      rate_q          <= rate_d;
      dom_q           <= dom_d;
      dom_placed_q    <= dom_placed_d;
      din_ready_q     <= din_ready_d;
      absorb_word_q   <= absorb_word_d;
      state_reg_sel_q <= state_reg_sel_d;
      xor_state_q     <= xor_state_d;
      call_q          <= call_d;
      done_q          <= done_d;
    end
  end

  assign din_ready         = din_ready_q;
  assign absorb_word       = absorb_word_q;
  assign state_reg_sel     = state_reg_sel_q;
  assign xor_state         = xor_state_q;
  assign call_keccak_f1600 = call_q;
  assign done              = done_q;

endmodule
